// File: rtl/respawn_controller.sv
`default_nettype none
// ============================================================================
// Module      : respawn_controller
// Description : Per-player life-cycle controller. Turns a collision hit into
//               a one-cycle kill pulse for the death timer, follows the
//               timer's death level, waits a respawn delay, latches a spawn
//               X position relative to the opponent, then runs a blinking
//               invincibility window before handing control back.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   hit         in   collision hit on this player (level or pulse)
//   death       in   death level from the death timer
//   round_end   in   synchronous round abort (highest priority)
//   enemy_x     in   opponent X position [X_W]
//   kill        out  one-cycle pulse to the death timer's active input
//   abort       out  one-cycle pulse to the death timer's premature_stop
//   alive       out  player is controllable
//   visible     out  player sprite enable
//   invincible  out  hits ignored
//   respawn     out  one-cycle pulse; spawn_x is valid
//   spawn_x     out  registered spawn position [X_W]
//   deaths      out  death count [8]
// Build option:
//   RESPAWN_DEATH_COUNT_EN - when defined, deaths counts kill pulses and
//   saturates at 255 (cleared only by reset_n); otherwise deaths is 0.
// ============================================================================
module respawn_controller #(
    parameter int CNT_W         = 27,
    parameter int RESPAWN_DELAY = 50000000,
    parameter int PROTECT_TIME  = 100000000,
    parameter int BLINK_PERIOD  = 6250000,
    parameter int X_W           = 11,
    parameter int SCREEN_W      = 1024,
    parameter int SPAWN_OFFSET  = 200,
    parameter int SPAWN_INIT    = 256
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           hit,
    input  logic           death,
    input  logic           round_end,
    input  logic [X_W-1:0] enemy_x,
    output logic           kill,
    output logic           abort,
    output logic           alive,
    output logic           visible,
    output logic           invincible,
    output logic           respawn,
    output logic [X_W-1:0] spawn_x,
    output logic [7:0]     deaths
);

    typedef enum logic [2:0] {
        S_ALIVE   = 3'd0,
        S_ARMED   = 3'd1,
        S_DEAD    = 3'd2,
        S_DELAY   = 3'd3,
        S_PROTECT = 3'd4
    } state_t;

    // ARMED gives the death timer 4 cycles to answer before we stop waiting.
    localparam logic [CNT_W-1:0] c_armed_last   = CNT_W'(3);
    localparam logic [CNT_W-1:0] c_delay_last   = CNT_W'(RESPAWN_DELAY - 1);
    localparam logic [CNT_W-1:0] c_protect_last = CNT_W'(PROTECT_TIME - 1);
    localparam logic [CNT_W-1:0] c_blink_last   = CNT_W'(BLINK_PERIOD - 1);
    localparam logic [X_W-1:0]   c_half         = X_W'(SCREEN_W / 2);
    localparam logic [X_W:0]     c_off_wide     = (X_W+1)'(SPAWN_OFFSET);
    localparam logic [X_W:0]     c_max_wide     = (X_W+1)'(SCREEN_W - 1);
    localparam logic [X_W-1:0]   c_spawn_init   = X_W'(SPAWN_INIT);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_blink;
    logic             r_kill;
    logic             r_abort;
    logic             r_alive;
    logic             r_visible;
    logic             r_invincible;
    logic             r_respawn;
    logic [X_W-1:0]   r_spawn_x;

    logic [X_W:0]     w_ex_wide;
    logic [X_W:0]     w_sum;
    logic [X_W-1:0]   w_spawn;
    logic             w_kill_now;

    // A hit only counts in ALIVE and only when no round abort competes.
    assign w_kill_now = (r_state == S_ALIVE) && hit && !round_end;

    // Spawn position: one extra bit so neither direction can wrap.
    assign w_ex_wide = {1'b0, enemy_x};
    assign w_sum     = w_ex_wide + c_off_wide;

    always_comb begin
        w_spawn = enemy_x;
        if (enemy_x >= c_half) begin
            if (w_ex_wide >= c_off_wide) begin
                w_spawn = enemy_x - c_off_wide[X_W-1:0];
            end else begin
                w_spawn = '0;
            end
        end else begin
            if (w_sum > c_max_wide) begin
                w_spawn = c_max_wide[X_W-1:0];
            end else begin
                w_spawn = w_sum[X_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_ALIVE;
            r_cnt        <= '0;
            r_blink      <= '0;
            r_kill       <= 1'b0;
            r_abort      <= 1'b0;
            r_alive      <= 1'b1;
            r_visible    <= 1'b1;
            r_invincible <= 1'b0;
            r_respawn    <= 1'b0;
            r_spawn_x    <= c_spawn_init;
        end else begin
            r_kill    <= 1'b0;
            r_abort   <= 1'b0;
            r_respawn <= 1'b0;
            if (round_end) begin
                // The death timer only needs stopping while it may be running.
                r_abort      <= (r_state == S_ARMED) || (r_state == S_DEAD);
                r_state      <= S_ALIVE;
                r_cnt        <= '0;
                r_blink      <= '0;
                r_alive      <= 1'b1;
                r_visible    <= 1'b1;
                r_invincible <= 1'b0;
            end else begin
                case (r_state)
                    S_ALIVE: begin
                        if (hit) begin
                            r_kill    <= 1'b1;
                            r_state   <= S_ARMED;
                            r_cnt     <= '0;
                            r_alive   <= 1'b0;
                            r_visible <= 1'b0;
                        end
                    end
                    S_ARMED: begin
                        if (death) begin
                            r_state <= S_DEAD;
                        end else if (r_cnt == c_armed_last) begin
                            r_state   <= S_DELAY;
                            r_cnt     <= '0;
                            r_spawn_x <= w_spawn;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_DEAD: begin
                        if (!death) begin
                            r_state   <= S_DELAY;
                            r_cnt     <= '0;
                            r_spawn_x <= w_spawn;
                        end
                    end
                    S_DELAY: begin
                        if (r_cnt == c_delay_last) begin
                            r_state      <= S_PROTECT;
                            r_cnt        <= '0;
                            r_blink      <= '0;
                            r_respawn    <= 1'b1;
                            r_alive      <= 1'b1;
                            r_visible    <= 1'b1;
                            r_invincible <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_PROTECT: begin
                        if (r_cnt == c_protect_last) begin
                            r_state      <= S_ALIVE;
                            r_cnt        <= '0;
                            r_blink      <= '0;
                            r_visible    <= 1'b1;
                            r_invincible <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            if (r_blink == c_blink_last) begin
                                r_blink   <= '0;
                                r_visible <= ~r_visible;
                            end else begin
                                r_blink <= r_blink + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_ALIVE;
                    end
                endcase
            end
        end
    end

    assign kill       = r_kill;
    assign abort      = r_abort;
    assign alive      = r_alive;
    assign visible    = r_visible;
    assign invincible = r_invincible;
    assign respawn    = r_respawn;
    assign spawn_x    = r_spawn_x;

`ifdef RESPAWN_DEATH_COUNT_EN
    logic [7:0] r_deaths;

    // Survives round_end on purpose: it is a match statistic, not round state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_deaths <= 8'd0;
        end else if (w_kill_now && (r_deaths != 8'hFF)) begin
            r_deaths <= r_deaths + 8'd1;
        end
    end

    assign deaths = r_deaths;
`else
    assign deaths = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_respawn_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_respawn_controller
// Description : Scoreboard bench for respawn_controller. A timestamp-based
//               reference model pushes the expected outputs of every clock
//               edge into a queue; a monitor on the falling edge pops and
//               compares. Two instances differ only in SPAWN_OFFSET so both
//               spawn clamps are reachable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_respawn_controller;

    localparam int RD  = 10;
    localparam int PT  = 16;
    localparam int BP  = 4;
    localparam int SW  = 1024;
    localparam int OFA = 200;
    localparam int OFB = 700;
`ifdef RESPAWN_DEATH_COUNT_EN
    localparam bit DC_EN = 1'b1;
`else
    localparam bit DC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n, hit, death, round_end;
    logic [10:0] enemy_x;
    logic        a_kill, a_abort, a_alive, a_visible, a_invincible, a_respawn;
    logic [10:0] a_spawn_x;
    logic [7:0]  a_deaths;
    logic        b_kill, b_abort, b_alive, b_visible, b_invincible, b_respawn;
    logic [10:0] b_spawn_x;
    logic [7:0]  b_deaths;

    respawn_controller #(.RESPAWN_DELAY(RD), .PROTECT_TIME(PT), .BLINK_PERIOD(BP),
                         .SPAWN_OFFSET(OFA)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .hit(hit), .death(death), .round_end(round_end),
        .enemy_x(enemy_x), .kill(a_kill), .abort(a_abort), .alive(a_alive),
        .visible(a_visible), .invincible(a_invincible), .respawn(a_respawn),
        .spawn_x(a_spawn_x), .deaths(a_deaths));

    respawn_controller #(.RESPAWN_DELAY(RD), .PROTECT_TIME(PT), .BLINK_PERIOD(BP),
                         .SPAWN_OFFSET(OFB)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .hit(hit), .death(death), .round_end(round_end),
        .enemy_x(enemy_x), .kill(b_kill), .abort(b_abort), .alive(b_alive),
        .visible(b_visible), .invincible(b_invincible), .respawn(b_respawn),
        .spawn_x(b_spawn_x), .deaths(b_deaths));

    always #5 clk = ~clk;

    typedef struct {
        int kill, abort, alive, visible, invincible, respawn, spawn_a, spawn_b, deaths;
    } exp_t;
    typedef struct { int a; int b; } sp_t;

    exp_t exp_q[$];
    sp_t  resp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int spawn_of(input int ex, input int off);
        if (ex >= SW / 2) return (ex < off) ? 0 : ex - off;
        return (ex + off > SW - 1) ? SW - 1 : ex + off;
    endfunction

    // ---------------- reference model (edge timestamps) ----------------
    int m_n, m_tkill, m_tfree, m_kills, m_spa, m_spb;
    bit m_seen_death;

    always @(posedge clk) begin
        exp_t e;
        bit   ep;
        e = '{default: 0};
        if (!reset_n) begin
            m_n = 0; m_tkill = -1; m_tfree = -1; m_kills = 0;
            m_spa = 256; m_spb = 256; m_seen_death = 0;
        end else begin
            ep = (m_tkill >= 0);
            if (round_end) begin
                e.abort = (ep && m_tfree < 0) ? 1 : 0;
                if (ep && m_tfree >= 0 && m_n <= m_tfree + RD && resp_q.size() > 0)
                    void'(resp_q.pop_back());
                m_tkill = -1; m_tfree = -1; m_seen_death = 0;
            end else if (!ep) begin
                if (hit) begin
                    m_tkill = m_n; m_tfree = -1; m_seen_death = 0;
                    e.kill = 1; m_kills++;
                end
            end else if (m_tfree < 0) begin
                if ((m_seen_death && !death) ||
                    (!m_seen_death && !death && m_n - m_tkill == 4)) begin
                    m_tfree = m_n;
                    m_spa = spawn_of(int'(enemy_x), OFA);
                    m_spb = spawn_of(int'(enemy_x), OFB);
                    resp_q.push_back('{a: m_spa, b: m_spb});
                end else if (death) begin
                    m_seen_death = 1;
                end
            end else begin
                if (m_n == m_tfree + RD) e.respawn = 1;
                if (m_n == m_tfree + RD + PT) m_tkill = -1;
            end
            m_n++;
        end
        if (m_tkill < 0) begin
            e.alive = 1; e.visible = 1; e.invincible = 0;
        end else if (m_tfree < 0 || (m_n - 1) < m_tfree + RD) begin
            e.alive = 0; e.visible = 0; e.invincible = 0;
        end else begin
            e.alive = 1; e.invincible = 1;
            e.visible = (((m_n - 1 - (m_tfree + RD)) / BP) % 2 == 0) ? 1 : 0;
        end
        e.spawn_a = m_spa;
        e.spawn_b = m_spb;
        e.deaths  = DC_EN ? ((m_kills > 255) ? 255 : m_kills) : 0;
        exp_q.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        sp_t  s;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("kill",       int'(a_kill),       e.kill);
            chk("abort",      int'(a_abort),      e.abort);
            chk("alive",      int'(a_alive),      e.alive);
            chk("visible",    int'(a_visible),    e.visible);
            chk("invincible", int'(a_invincible), e.invincible);
            chk("respawn",    int'(a_respawn),    e.respawn);
            chk("spawn_x_a",  int'(a_spawn_x),    e.spawn_a);
            chk("deaths",     int'(a_deaths),     e.deaths);
            chk("kill_b",     int'(b_kill),       e.kill);
            chk("alive_b",    int'(b_alive),      e.alive);
            chk("visible_b",  int'(b_visible),    e.visible);
            chk("abort_b",    int'(b_abort) + 2 * int'(b_invincible), e.abort + 2 * e.invincible);
            chk("respawn_b",  int'(b_respawn),    e.respawn);
            chk("spawn_x_b",  int'(b_spawn_x),    e.spawn_b);
            chk("deaths_b",   int'(b_deaths),     e.deaths);
        end
        if (a_respawn) begin
            if (resp_q.size() == 0) begin
                chk("respawn_unexpected", 1, 0);
            end else begin
                s = resp_q.pop_front();
                chk("respawn_pos_a", int'(a_spawn_x), s.a);
                chk("respawn_pos_b", int'(b_spawn_x), s.b);
            end
        end
    end

    // ---------------- death timer stand-in ----------------
    bit dt_en  = 1'b1;
    int dt_len = 20;

    always begin
        @(negedge clk);
        if (reset_n && dt_en && a_kill) begin
            @(posedge clk);
            #1 death = 1'b1;
            repeat (dt_len) @(posedge clk);
            #1 death = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic episode(input int ex, input int wait_cycles);
        enemy_x = 11'(ex);
        hit = 1'b1; tick(1); hit = 1'b0;
        tick(wait_cycles);
    endtask

    initial begin
        int ex_tab[4];
        ex_tab = '{900, 100, 600, 400};
        hit = 1'b0; death = 1'b0; round_end = 1'b0; enemy_x = '0; reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(2);

        // Nominal lives at four opponent positions (covers both clamps on b).
        foreach (ex_tab[i]) episode(ex_tab[i], 60);

        // Hit held high through whole lives, including protection.
        enemy_x = 11'd700; hit = 1'b1; tick(150); hit = 1'b0; tick(30);

        // round_end while DEAD, then while DELAY.
        episode(300, 4); round_end = 1'b1; tick(1); round_end = 1'b0; tick(30);
        dt_len = 2;
        episode(800, 8); round_end = 1'b1; tick(1); round_end = 1'b0; tick(10);

        // Death timer silent: ARMED must time out and still respawn.
        dt_en = 1'b0; episode(520, 40); dt_en = 1'b1;

        // Asynchronous reset in the middle of DELAY.
        episode(50, 8);
        #2 reset_n = 1'b0;
        exp_q.delete(); resp_q.delete();
        #1;
        chk("rst_kill",    int'(a_kill),       0);
        chk("rst_abort",   int'(a_abort),      0);
        chk("rst_alive",   int'(a_alive),      1);
        chk("rst_visible", int'(a_visible),    1);
        chk("rst_invinc",  int'(a_invincible), 0);
        chk("rst_respawn", int'(a_respawn),    0);
        chk("rst_spawn",   int'(a_spawn_x),    256);
        chk("rst_deaths",  int'(a_deaths),     0);
        tick(2); reset_n = 1'b1; tick(3);

        // Many short lives: death count saturation.
        dt_en = 1'b0;
        for (int i = 0; i < 260; i++) begin
            hit = 1'b1; tick(1);
            hit = 1'b0; round_end = 1'b1; tick(1);
            round_end = 1'b0; tick(1);
        end

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            hit       = ($urandom_range(0, 9) == 0);
            round_end = ($urandom_range(0, 63) == 0);
            enemy_x   = 11'($urandom_range(0, 2047));
            dt_len    = $urandom_range(1, 25);
            dt_en     = ($urandom_range(0, 4) != 0);
            tick(1);
        end
        hit = 1'b0; round_end = 1'b0; dt_en = 1'b0;
        tick(80);
        chk("respawn_queue_drained", resp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
